// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if
// Bundles the receive-side signals of the UART deserializer.
// master: whoever drives the serial line and the oversampling tick.
// slave : the deserializer itself.
// rx_state exposes the receiver FSM state for checkers and debug.
interface uart_rx_deserializer_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 sample_ENABLE;
    logic                 RxD;
    logic [DATA_BITS-1:0] Rx_DATA;
    logic                 Rx_VALID;
    logic                 Rx_PERROR;
    logic                 Rx_FERROR;
    logic                 Rx_BUSY;
    logic [2:0]           rx_state;

    modport master (
        output sample_ENABLE,
        output RxD,
        input  Rx_DATA,
        input  Rx_VALID,
        input  Rx_PERROR,
        input  Rx_FERROR,
        input  Rx_BUSY,
        input  rx_state
    );

    modport slave (
        input  sample_ENABLE,
        input  RxD,
        output Rx_DATA,
        output Rx_VALID,
        output Rx_PERROR,
        output Rx_FERROR,
        output Rx_BUSY,
        output rx_state
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// UART receive stage driven by a 16x (OVERSAMPLE) sample_ENABLE tick.
// Synchronises RxD, detects the start bit, samples each bit mid-period,
// checks parity and stop bit and reports the word with one-cycle strobes.
//
// Optional macro UART_RX_MAJORITY_EN: each bit becomes the 2-of-3 majority
// of the samples at cnt == M-1, M, M+1 (decision at M+1).
//
// Output handshake: there is no backpressure. Rx_VALID / Rx_PERROR /
// Rx_FERROR are single-cycle strobes; the consumer must capture Rx_DATA in
// the cycle a strobe is high. Rx_DATA then holds until the next frame ends.
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = 16
) (
    input logic                   clk,
    input logic                   reset,
    uart_rx_deserializer_if.slave rx
);

    localparam int CW = $clog2(OVERSAMPLE + 1);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_M   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M   = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

`ifdef UART_RX_MAJORITY_EN
    // Decisions land one tick late (M+1); restarting the counter at 1 keeps
    // consecutive sampling points exactly OVERSAMPLE ticks apart.
    localparam logic [CW-1:0] CNT_RESTART = CW'(1);
`else
    localparam logic [CW-1:0] CNT_RESTART = '0;
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic                 rx_meta;
    logic                 rxs;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic                 stop_bit;
    logic                 armed;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 busy_q;

    logic [CW-1:0]        m_cnt;
    logic                 samp_hit;
    logic                 samp_val;
    logic                 perr_now;

`ifdef UART_RX_MAJORITY_EN
    logic                 s_a;
    logic                 s_b;

    // Capture the two early votes of the majority window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_a <= 1'b1;
            s_b <= 1'b1;
        end else if (rx.sample_ENABLE) begin
            if (cnt == m_cnt - CW'(1)) s_a <= rxs;
            if (cnt == m_cnt)          s_b <= rxs;
        end
    end
`endif

    // Nominal sampling count for the current bit, sample strobe and value.
    always_comb begin
        m_cnt = (state == S_START) ? HALF_M : FULL_M;
`ifdef UART_RX_MAJORITY_EN
        samp_hit = rx.sample_ENABLE && (cnt == m_cnt + CW'(1));
        samp_val = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
`else
        samp_hit = rx.sample_ENABLE && (cnt == m_cnt);
        samp_val = rxs;
`endif
        perr_now = (PARITY_EN != 0) &&
                   (((^shift_reg) ^ parity_bit) != (PARITY_ODD != 0));
    end

    // Two-flop synchroniser; idles high so reset does not fake a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx.RxD;
            rxs     <= rx_meta;
        end
    end

    // Frame FSM: counters advance only on ticks; strobes last one clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            stop_bit   <= 1'b1;
            armed      <= 1'b1;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx.sample_ENABLE) begin
                        if (rxs) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state  <= S_START;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (samp_hit) begin
                        if (!samp_val) begin
                            state   <= S_DATA;
                            cnt     <= CNT_RESTART;
                            bit_idx <= '0;
                        end else begin
                            // Glitch shorter than half a bit: quietly drop it.
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else if (rx.sample_ENABLE) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (samp_hit) begin
                        shift_reg[bit_idx] <= samp_val;
                        cnt                <= CNT_RESTART;
                        if (bit_idx == LAST_BIT) begin
                            state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end else if (rx.sample_ENABLE) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (samp_hit) begin
                        parity_bit <= samp_val;
                        cnt        <= CNT_RESTART;
                        state      <= S_STOP;
                    end else if (rx.sample_ENABLE) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (samp_hit) begin
                        stop_bit <= samp_val;
                        state    <= S_FINISH;
                    end else if (rx.sample_ENABLE) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FINISH: begin
                    // Publish at mid-stop-bit, leaving half a bit to resync.
                    data_q  <= shift_reg;
                    perr_q  <= perr_now;
                    ferr_q  <= !stop_bit;
                    valid_q <= !perr_now && stop_bit;
                    busy_q  <= 1'b0;
                    // A low stop bit may be a break: wait for idle before rearming.
                    if (!stop_bit) armed <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.Rx_DATA   = data_q;
    assign rx.Rx_VALID  = valid_q;
    assign rx.Rx_PERROR = perr_q;
    assign rx.Rx_FERROR = ferr_q;
    assign rx.Rx_BUSY   = busy_q;
    assign rx.rx_state  = state;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
// Directed frames with hand-computed expectations. Each expected frame
// result {perror, ferror, data} is queued when the frame is sent; a monitor
// pops and compares whenever the DUT raises a strobe.
// baud_select 3'b111 is modelled as a tick every 4 clk, 3'b110 every 8 clk.
module tb_uart_rx_deserializer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_rx_deserializer_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_deserializer dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx_if)
    );

    int tests = 0;
    int fails = 0;

    logic [9:0] exp_q[$];

    int tick_div      = 4;
    int div_cnt       = 0;
    int busy_len      = 0;
    int last_busy_len = 0;
    logic busy_prev   = 1'b0;

    // ---------------- tick generator ----------------
    initial begin
        rx_if.sample_ENABLE = 1'b0;
        forever begin
            @(negedge clk);
            if (div_cnt >= tick_div - 1) begin
                div_cnt = 0;
                rx_if.sample_ENABLE = 1'b1;
            end else begin
                div_cnt++;
                rx_if.sample_ENABLE = 1'b0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic send_ticks(input logic v, input int n);
        rx_if.RxD = v;
        for (int k = 0; k < n; ) begin
            @(posedge clk);
            if (rx_if.sample_ENABLE) k++;
        end
        #1;
    endtask

    task automatic idle_bits(input int n);
        send_ticks(1'b1, 16 * n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_ticks(1'b0, 16);
        for (int i = 0; i < 8; i++) send_ticks(d[i], 16);
        send_ticks(par, 16);
        send_ticks(stp, 16);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr);
        exp_q.push_back({perr, ferr, d});
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, int'({rx_if.Rx_DATA, rx_if.Rx_VALID, rx_if.Rx_PERROR,
                          rx_if.Rx_FERROR, rx_if.Rx_BUSY}), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [9:0] e;
        logic [9:0] got;
        logic       want_valid;
        forever begin
            @(negedge clk);
            if (rx_if.Rx_BUSY) busy_len++;
            if (busy_prev && !rx_if.Rx_BUSY) begin
                last_busy_len = busy_len;
                busy_len = 0;
            end
            busy_prev = rx_if.Rx_BUSY;
            if (rx_if.Rx_VALID || rx_if.Rx_PERROR || rx_if.Rx_FERROR) begin
                got = {rx_if.Rx_PERROR, rx_if.Rx_FERROR, rx_if.Rx_DATA};
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_strobe: got %0h valid=%0b expected none",
                             got, rx_if.Rx_VALID);
                end else begin
                    e = exp_q.pop_front();
                    want_valid = !(e[9] | e[8]);
                    if (got !== e || rx_if.Rx_VALID !== want_valid) begin
                        fails++;
                        $display("FAIL frame: got %0h valid=%0b expected %0h valid=%0b",
                                 got, rx_if.Rx_VALID, e, want_valid);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        rx_if.RxD = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_outputs");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_bits(2);

        // Clean frame 0xA5, even parity 0.
        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(2);
        // 168 ticks from start detect to mid-stop, 4 clk per tick, +1 clk.
        tests++;
        if (last_busy_len < 660 || last_busy_len > 690) begin
            fails++;
            $display("FAIL busy_len: got %0d expected 660..690", last_busy_len);
        end

        // Glitch of 4 ticks must be rejected.
        send_ticks(1'b0, 4);
        idle_bits(2);
        check("glitch_busy", int'(rx_if.Rx_BUSY), 0);
        check("glitch_data", int'(rx_if.Rx_DATA), 8'hA5);

        // Parity error: 0x3C has even ones, so parity 1 is wrong.
        expect_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle_bits(2);

        // Framing error followed by a 40-bit break, then a good frame.
        expect_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b0);
        send_ticks(1'b0, 16 * 40);
        idle_bits(2);
        expect_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle_bits(2);

        // Reset in the middle of data bit 3 of 0xFF.
        send_ticks(1'b0, 16);
        for (int i = 0; i < 3; i++) send_ticks(1'b1, 16);
        send_ticks(1'b1, 8);
        reset = 1'b1;
        rx_if.RxD = 1'b1;
        @(negedge clk);
        check_reset_outputs("midframe_reset_outputs");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_bits(2);
        expect_frame(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1);
        idle_bits(2);

        // Back-to-back frames at two tick rates.
        for (int r = 0; r < 2; r++) begin
            tick_div = (r == 0) ? 4 : 8;
            idle_bits(1);
            expect_frame(8'h01, 1'b0, 1'b0);
            expect_frame(8'h80, 1'b0, 1'b0);
            expect_frame(8'hFF, 1'b0, 1'b0);
            send_frame(8'h01, 1'b1, 1'b1);
            send_frame(8'h80, 1'b1, 1'b1);
            send_frame(8'hFF, 1'b0, 1'b1);
            idle_bits(2);
        end

        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- UART receive stage, directly downstream of baud_controller; consumes its sample_ENABLE pulse, one clk cycle wide, at 16x the baud rate.
- Synchronises the serial RxD line and detects the start bit.
- Samples each bit at mid-period, checks parity and stop bit, then presents the received word with a one-cycle valid strobe and error flags.
- Feeds the downstream consumer (FIFO / seven-segment display logic).

Parameters:
- DATA_BITS, 8: data bits per frame, sent LSB first (legal range 5..8).
- PARITY_EN, 1: 1 = a parity bit follows the data; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.
- OVERSAMPLE, 16: sample_ENABLE ticks per bit period. Must be even.

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-high reset.
- sample_ENABLE, input, 1: oversampling tick from baud_controller.
- RxD, input, 1: serial line; idle level is 1.
- Rx_DATA, output, DATA_BITS: last received word.
- Rx_VALID, output, 1: one-cycle strobe; frame received with no errors.
- Rx_PERROR, output, 1: one-cycle strobe; parity mismatch.
- Rx_FERROR, output, 1: one-cycle strobe; stop bit sampled as 0.
- Rx_BUSY, output, 1: high from start detect until the frame ends.

Behaviour:
- Reset values (asynchronous):
  - Rx_DATA=0; Rx_VALID=0; Rx_PERROR=0; Rx_FERROR=0; Rx_BUSY=0.
  - State=IDLE; synchroniser flops=1; armed=1.
- RxD passes through a 2-flop synchroniser (rxs). Every decision uses rxs.
- All counters advance only on cycles where sample_ENABLE=1. Between ticks, state holds.
- IDLE:
  - On a tick with rxs=1: set armed=1.
  - On a tick with armed=1 and rxs=0: go to START, cnt=0, Rx_BUSY=1.
- START:
  - cnt increments on each tick.
  - At cnt==OVERSAMPLE/2-1, sample the line:
    - 0: go to DATA, cnt=0, bit index=0.
    - 1: false start; go to IDLE, Rx_BUSY=0, no strobes.
- DATA:
  - At cnt==OVERSAMPLE-1, shift the sample into the shift register at the current bit index (LSB first), then reset cnt.
  - After bit DATA_BITS-1, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: at cnt==OVERSAMPLE-1, capture the parity bit and go to STOP.
- STOP: at cnt==OVERSAMPLE-1, sample the stop bit, then on the next clk edge:
  - Rx_DATA <= shift register (updated even when an error is flagged).
  - Rx_PERROR = PARITY_EN and (XOR(data, parity bit) != PARITY_ODD).
  - Rx_FERROR = (stop sample == 0).
  - Rx_VALID = neither error.
  - Each strobe is high for exactly one clk cycle.
  - Return to IDLE with Rx_BUSY=0. This happens at mid-stop-bit, leaving half a bit of resync margin.
- After a framing error: armed=0, so a held-low line (break) does not retrigger. A new start is accepted only after rxs=1 is seen on a tick.
- Latency: strobe appears 1 clk after the mid-stop sampling tick.
  - Start falling edge to strobe ≈ (1+DATA_BITS+PARITY_EN+0.5)·OVERSAMPLE ticks, plus 2–3 clk.
- Bit-period sampling point: OVERSAMPLE ticks after the previous sampling point.
- If sample_ENABLE is stuck at 0, the FSM freezes with no timeout.
- If reset is asserted mid-frame: the partial frame is discarded with no strobes. After release the block is in IDLE and armed.
- Rx_DATA holds its value between frames. Strobes are mutually exclusive with each other except PERROR+FERROR, which may assert together.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every bit (start, data, parity, stop) is the 2-of-3 majority of the rxs samples taken at ticks cnt==M-1, M, M+1, where M is the nominal sampling count.
  - The decision is made at cnt==M+1.
  - All latencies grow by 1 tick.
- Undefined: single sample at cnt==M, as described in Behaviour.

Test Plan:
- Default parameters, baud_select=3'b111 stimulus, line idle: send 0xA5 (parity 0, stop 1).
  - Expect one Rx_VALID pulse, Rx_DATA=8'hA5, PERROR=FERROR=0.
  - Expect Rx_BUSY high for ≈10.5 bit periods.
- Glitch rejection: drive RxD low for 4 ticks, then high.
  - Expect no strobes, Rx_BUSY returns to 0, Rx_DATA unchanged.
- Parity error: send 0x3C with parity bit 1.
  - Expect Rx_PERROR pulse, Rx_VALID=0, Rx_DATA=8'h3C.
- Framing error / break: send 0x00 with stop=0, then hold RxD=0 for 40 bit periods, then idle high, then send 0x5A.
  - Expect exactly one FERROR for the first frame and no frames during the break.
  - Expect VALID with Rx_DATA=8'h5A afterwards.
- Reset mid-frame: assert reset during data bit 3 of 0xFF, release, then send 0x81.
  - Expect all outputs 0 during reset, no strobe for the aborted frame, VALID with 8'h81 after.
- Back-to-back: send frames 0x01, 0x80, 0xFF with no idle gap, at both baud_select 3'b111 and 3'b110.
  - Expect three VALID pulses in order with the correct data.
